// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: derives the slow cpu clock and cpu reset from the board clock.
// Supports free-running RUN, HALT and single STEP, driven by debounced push-buttons.
module cpu_clk_ctrl #(
  parameter int unsigned HALF_PERIOD     = 131072,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter bit          START_RUN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run,
  input  logic btn_step,
  output logic cpu_clk,
  output logic cpu_rst,
  output logic tick,
  output logic running
);

  localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam state_t RESET_STATE = START_RUN ? ST_RUN : ST_HALT;

  // Button conditioning: index 0 is the run button, index 1 is the step button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db_level;
  logic [1:0]      db_prev;
  logic [DB_W-1:0] db_cnt [0:1];
  logic            run_press;
  logic            step_press;

  // Core state and the values computed for the next clk edge.
  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic             stop_req, stop_n;
  logic             clk_prev;
  logic             clk_n;
  logic             rst_n;
  logic             tick_n;
  logic             running_n;
  logic             terminal;
  logic             stopping;

  assign btn_raw    = {btn_step, btn_run};
  assign run_press  = db_level[0] & ~db_prev[0];
  assign step_press = db_level[1] & ~db_prev[1];
  assign terminal   = (div_cnt == DIV_LAST);

  // Synchronize both buttons and accept a new level only after it has held long enough.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db_level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next-state logic: mode transitions, the divider and the cpu clock/reset levels.
  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    clk_n    = cpu_clk;
    stop_n   = stop_req;
    stopping = stop_req | run_press;
    case (state)
      ST_HALT: begin
        clk_n  = 1'b0;
        div_n  = '0;
        stop_n = 1'b0;
        if (run_press) begin
          state_n = ST_RUN;
        end else if (step_press) begin
          state_n = ST_STEP;
          clk_n   = 1'b1;
        end
      end
      ST_RUN: begin
        div_n = terminal ? '0 : div_cnt + 1'b1;
        if (run_press && !cpu_clk) begin
          state_n = ST_HALT;
          clk_n   = 1'b0;
        end else if (terminal) begin
          clk_n = ~cpu_clk;
          if (cpu_clk && stopping) begin
            state_n = ST_HALT;
            stop_n  = 1'b0;
          end
        end else if (run_press) begin
          stop_n = 1'b1;
        end
      end
      ST_STEP: begin
        div_n = terminal ? '0 : div_cnt + 1'b1;
        if (terminal) begin
          if (cpu_clk) begin
            clk_n = 1'b0;
          end else begin
            state_n = ST_HALT;
          end
        end
      end
      default: begin
        state_n = ST_HALT;
        clk_n   = 1'b0;
        div_n   = '0;
        stop_n  = 1'b0;
      end
    endcase
    if (state_n != state) begin
      div_n = '0;
    end
    tick_n    = clk_n & ~cpu_clk;
    rst_n     = cpu_rst & ~(clk_prev & ~cpu_clk);
    running_n = (state_n == ST_RUN);
  end

  // State and output registers; reset overrides any mode including a step in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RESET_STATE;
      div_cnt  <= '0;
      stop_req <= 1'b0;
      cpu_clk  <= 1'b0;
      clk_prev <= 1'b0;
      cpu_rst  <= 1'b1;
      tick     <= 1'b0;
      running  <= START_RUN;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      stop_req <= stop_n;
      cpu_clk  <= clk_n;
      clk_prev <= cpu_clk;
      cpu_rst  <= rst_n;
      tick     <= tick_n;
      running  <= running_n;
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: drives button presses, glitches and resets into cpu_clk_ctrl and
// compares every cycle's outputs with a mode/phase-countdown reference model.
module tb_cpu_clk_ctrl;

  localparam int HP = 4;
  localparam int DB = 3;
  localparam bit SR = 1'b1;

  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  localparam int W_TICK = 0;
  localparam int W_HALT = 1;
  localparam int W_STEP_HIGH = 2;

  typedef struct packed {
    logic clk_v;
    logic rst_v;
    logic tick_v;
    logic run_v;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run = 1'b0;
  logic btn_step = 1'b0;
  logic cpu_clk;
  logic cpu_rst;
  logic tick;
  logic running;

  int n_checks = 0;
  int n_fails = 0;
  int cyc = 0;

  outs_t exp_q[$];
  bit run_act[int];
  bit step_act[int];

  int m_mode = M_HALT;
  int m_left = HP;
  bit m_clk = 1'b0;
  bit m_stop = 1'b0;
  bit m_rst = 1'b1;
  bit m_fell = 1'b0;
  bit m_tick = 1'b0;

  cpu_clk_ctrl #(
    .HALF_PERIOD(HP),
    .DEBOUNCE_CYCLES(DB),
    .START_RUN(SR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_run(btn_run),
    .btn_step(btn_step),
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .tick(tick),
    .running(running)
  );

  // Board clock.
  always #5 clk = ~clk;

  // Reference model: advances one board cycle per edge and queues the expected outputs.
  always @(posedge clk) begin : ref_model
    bit rp;
    bit sp;
    bit prev_clk;
    cyc = cyc + 1;
    rp = run_act.exists(cyc);
    sp = step_act.exists(cyc);
    if (rst) begin
      m_mode = SR ? M_RUN : M_HALT;
      m_clk  = 1'b0;
      m_left = HP;
      m_stop = 1'b0;
      m_rst  = 1'b1;
      m_fell = 1'b0;
      m_tick = 1'b0;
    end else begin
      prev_clk = m_clk;
      if (m_fell) m_rst = 1'b0;
      case (m_mode)
        M_HALT: begin
          if (rp) begin
            m_mode = M_RUN;
            m_left = HP;
          end else if (sp) begin
            m_mode = M_STEP;
            m_clk  = 1'b1;
            m_left = HP;
          end
        end
        M_RUN: begin
          if (rp && !m_clk) begin
            m_mode = M_HALT;
          end else begin
            if (rp) m_stop = 1'b1;
            if (m_left == 1) begin
              m_left = HP;
              m_clk  = !m_clk;
              if (!m_clk && m_stop) begin
                m_mode = M_HALT;
                m_stop = 1'b0;
              end
            end else begin
              m_left--;
            end
          end
        end
        default: begin
          if (m_left == 1) begin
            m_left = HP;
            if (m_clk) m_clk = 1'b0;
            else m_mode = M_HALT;
          end else begin
            m_left--;
          end
        end
      endcase
      m_tick = m_clk && !prev_clk;
      m_fell = prev_clk && !m_clk;
    end
    exp_q.push_back({m_clk, m_rst, m_tick, (m_mode == M_RUN)});
  end

  // Monitor: pops the expected outputs for each cycle and compares mid-cycle.
  always @(negedge clk) begin : monitor
    outs_t e;
    outs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {cpu_clk, cpu_rst, tick, running};
      checkOutput(e, a);
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input outs_t e, input outs_t a);
    n_checks++;
    if (a !== e) begin
      n_fails++;
      $display("[TB] FAIL outputs cyc=%0d got clk/rst/tick/running=%b%b%b%b expected %b%b%b%b",
               cyc, a.clk_v, a.rst_v, a.tick_v, a.run_v, e.clk_v, e.rst_v, e.tick_v, e.run_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the chosen buttons for 'hold' cycles and records when a real press should act.
  task automatic applyStimulus(input bit do_run, input bit do_step, input int hold);
    if (do_run) btn_run = 1'b1;
    if (do_step) btn_step = 1'b1;
    if (hold >= DB) begin
      if (do_run) run_act[cyc + DB + 3] = 1'b1;
      if (do_step) step_act[cyc + DB + 3] = 1'b1;
    end
    idle(hold);
    btn_run = 1'b0;
    btn_step = 1'b0;
  endtask

  function automatic bit model_cond(input int what);
    case (what)
      W_TICK: return m_tick;
      W_HALT: return m_mode == M_HALT;
      default: return (m_mode == M_STEP) && m_clk;
    endcase
  endfunction

  task automatic wait_model(input int what, input int budget, input string name);
    int n = 0;
    while (!model_cond(what) && n < budget) begin
      idle(1);
      n++;
    end
    if (!model_cond(what)) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL wait_%s got timeout after %0d cycles expected condition reached", name, budget);
    end
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    int kind;
    int hold;
    @(posedge clk);
    #1;
    idle(1);
    rst = 1'b0;

    $display("[TB] free run after reset");
    idle(40);

    $display("[TB] run glitch");
    applyStimulus(1'b1, 1'b0, 2);
    idle(20);

    $display("[TB] halt request during high phase");
    wait_model(W_TICK, 20, "tick");
    idle(3);
    applyStimulus(1'b1, 1'b0, 6);
    idle(10);
    wait_model(W_HALT, 30, "halt");
    idle(10);

    $display("[TB] single step with a second press during the step");
    applyStimulus(1'b0, 1'b1, 3);
    idle(4);
    applyStimulus(1'b0, 1'b1, 3);
    idle(20);

    $display("[TB] simultaneous run and step");
    applyStimulus(1'b1, 1'b1, 4);
    idle(20);

    $display("[TB] reset during step high phase");
    applyStimulus(1'b1, 1'b0, 4);
    wait_model(W_HALT, 40, "halt2");
    idle(6);
    applyStimulus(1'b0, 1'b1, 4);
    wait_model(W_STEP_HIGH, 10, "step_high");
    idle(1);
    apply_reset(2);
    idle(30);

    $display("[TB] random presses");
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      hold = $urandom_range(DB + 1, DB + 4);
      case (kind)
        0: applyStimulus(1'b1, 1'b0, hold);
        1: applyStimulus(1'b0, 1'b1, hold);
        2: applyStimulus(1'b1, 1'b1, hold);
        3: begin
          if ($urandom_range(0, 1) == 0) applyStimulus(1'b1, 1'b0, $urandom_range(1, DB - 1));
          else applyStimulus(1'b0, 1'b1, $urandom_range(1, DB - 1));
        end
        default: idle(1);
      endcase
      idle($urandom_range(DB + 1, 14));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
